// File: rtl/board_pkg.sv
// board_pkg: shared constants, types and helpers for the board LED conditioning stage.
//   LED_* : bit positions in the 6-bit board LED vector
//   sync_t: bundle of the inputs that pass through the synchronizer
//   ms_div: sysclk cycles per millisecond (integer division)
//   cnt_w : bits needed to count 0..n-1 (at least 1)
package board_pkg;

    localparam int unsigned LED_W     = 6;
    localparam int unsigned LED_RED   = 0;
    localparam int unsigned LED_GREEN = 1;
    localparam int unsigned LED_RUN   = 2;
    localparam int unsigned LED_CPU   = 3;
    localparam int unsigned LED_RX    = 4;
    localparam int unsigned LED_TX    = 5;

    // Inputs carried through the synchronizer; unused cpu_led bits are not synchronized.
    typedef struct packed {
        logic [1:0] lamp;     // cpu_led[1:0], steady red/green
        logic       grant;    // cpu_led[3], CPU grant
        logic       run_n;
        logic       uart_rx;
        logic       uart_tx;
    } sync_t;

    // Synchronizer reset value: every input at its idle level.
    localparam sync_t SYNC_IDLE = '{lamp: 2'b00, grant: 1'b0, run_n: 1'b1,
                                    uart_rx: 1'b1, uart_tx: 1'b1};

    typedef enum logic [1:0] {
        HB_IDLE = 2'd0,
        HB_ON   = 2'd1,
        HB_OFF  = 2'd2
    } hb_state_t;

    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_stretch.sv
// led_stretch: one pulse-stretch channel.
//   sysclk, sys_rst_n : clock, async active-low reset
//   tick              : 1-cycle millisecond strobe
//   trig              : level trigger, (re)loads the on-time
//   lit               : channel lit (trigger high or on-time remaining)
module led_stretch #(
    parameter int unsigned STRETCH_MS = 50
) (
    input  logic sysclk,
    input  logic sys_rst_n,
    input  logic tick,
    input  logic trig,
    output logic lit
);

    localparam int unsigned CNT_W = $clog2(STRETCH_MS + 1);

    logic [CNT_W-1:0] cnt_q;

    // Remaining on-time in ms; a trigger wins over a simultaneous tick.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (trig) begin
            cnt_q <= CNT_W'(STRETCH_MS);
        end else if (tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign lit = trig | (cnt_q != '0);

endmodule

// File: rtl/board_led_ctrl.sv
// board_led_ctrl: conditions CPU board status into six active-low board LEDs.
//   sysclk, sys_rst_n : clock, async active-low reset
//   cpu_led[5:0]      : CPU LED vector, active-high (bits 2,4,5 ignored)
//   run_n             : CPU RUN_n, low while running
//   uart_rx, uart_tx  : UART pins, idle high
//   led[5:0]          : board LEDs, active-low
// Optional feature macro LED_HEARTBEAT_EN: blink led[2] while running
// instead of holding it steady.
module board_led_ctrl
    import board_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 39_321_600,
    parameter int unsigned STRETCH_MS = 50,
    parameter int unsigned HB_HALF_MS = 500
) (
    input  logic             sysclk,
    input  logic             sys_rst_n,
    input  logic [LED_W-1:0] cpu_led,
    input  logic             run_n,
    input  logic             uart_rx,
    input  logic             uart_tx,
    output logic [LED_W-1:0] led
);

    localparam int unsigned MS_DIV = ms_div(CLK_HZ);
    localparam int unsigned PRE_W  = cnt_w(MS_DIV);

    sync_t            sync_d_c;
    sync_t            sync_q1;
    sync_t            sync_q2;
    logic [PRE_W-1:0] pre_q;
    logic             tick_c;
    logic [2:0]       trig_c;
    logic [2:0]       lit_c;
    logic             run_lit_c;
    logic [LED_W-1:0] led_nx_c;
    logic             unused_c;

    // Ignored CPU LED bits and the heartbeat period (default build).
    assign unused_c = ^{cpu_led[5:4], cpu_led[2], HB_HALF_MS};

    always_comb begin
        sync_d_c         = SYNC_IDLE;
        sync_d_c.lamp    = cpu_led[1:0];
        sync_d_c.grant   = cpu_led[3];
        sync_d_c.run_n   = run_n;
        sync_d_c.uart_rx = uart_rx;
        sync_d_c.uart_tx = uart_tx;
    end

    // Two-flop synchronizer, reset to idle levels.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= SYNC_IDLE;
            sync_q2 <= SYNC_IDLE;
        end else begin
            sync_q1 <= sync_d_c;
            sync_q2 <= sync_q1;
        end
    end

    // Free-running millisecond prescaler.
    assign tick_c = (pre_q == PRE_W'(MS_DIV - 1));

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_q <= '0;
        end else if (tick_c) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    assign trig_c = {~sync_q2.uart_tx, ~sync_q2.uart_rx, sync_q2.grant};

    led_stretch #(.STRETCH_MS(STRETCH_MS)) u_cpu (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick_c),
        .trig      (trig_c[0]),
        .lit       (lit_c[0])
    );

    led_stretch #(.STRETCH_MS(STRETCH_MS)) u_rx (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick_c),
        .trig      (trig_c[1]),
        .lit       (lit_c[1])
    );

    led_stretch #(.STRETCH_MS(STRETCH_MS)) u_tx (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick_c),
        .trig      (trig_c[2]),
        .lit       (lit_c[2])
    );

`ifdef LED_HEARTBEAT_EN
    localparam int unsigned HB_W = cnt_w(HB_HALF_MS);

    hb_state_t       hb_q;
    hb_state_t       hb_nx_c;
    logic [HB_W-1:0] phase_q;
    logic [HB_W-1:0] phase_nx_c;
    logic            running_c;

    assign running_c = ~sync_q2.run_n;

    // Heartbeat state and phase register.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hb_q    <= HB_IDLE;
            phase_q <= '0;
        end else begin
            hb_q    <= hb_nx_c;
            phase_q <= phase_nx_c;
        end
    end

    // Entering run restarts the phase lit; each HB_HALF_MS ticks flips the lamp.
    always_comb begin
        hb_nx_c    = hb_q;
        phase_nx_c = phase_q;
        case (hb_q)
            HB_IDLE: begin
                if (running_c) begin
                    hb_nx_c    = HB_ON;
                    phase_nx_c = '0;
                end
            end
            HB_ON, HB_OFF: begin
                if (!running_c) begin
                    hb_nx_c    = HB_IDLE;
                    phase_nx_c = '0;
                end else if (tick_c) begin
                    if (phase_q == HB_W'(HB_HALF_MS - 1)) begin
                        phase_nx_c = '0;
                        hb_nx_c    = (hb_q == HB_ON) ? HB_OFF : HB_ON;
                    end else begin
                        phase_nx_c = phase_q + HB_W'(1);
                    end
                end
            end
            default: begin
                hb_nx_c    = HB_IDLE;
                phase_nx_c = '0;
            end
        endcase
    end

    // Lamp follows the next state so the output register shows it with input latency.
    always_comb begin
        run_lit_c = (hb_nx_c == HB_ON);
    end
`else
    assign run_lit_c = ~sync_q2.run_n;
`endif

    always_comb begin
        led_nx_c            = '1;
        led_nx_c[LED_RED]   = ~sync_q2.lamp[0];
        led_nx_c[LED_GREEN] = ~sync_q2.lamp[1];
        led_nx_c[LED_RUN]   = ~run_lit_c;
        led_nx_c[LED_CPU]   = ~lit_c[0];
        led_nx_c[LED_RX]    = ~lit_c[1];
        led_nx_c[LED_TX]    = ~lit_c[2];
    end

    // Output register; all LEDs dark in reset.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led <= '1;
        end else begin
            led <= led_nx_c;
        end
    end

endmodule

// File: tb/tb_board_led_ctrl.sv
// tb_board_led_ctrl: randomized scoreboard bench for board_led_ctrl.
// Expected LED vectors come from a millisecond-level reference model and are
// queued per cycle; an independent monitor pops and compares every cycle.
module tb_board_led_ctrl;

    localparam int MS_DIV = 10;    // CLK_HZ = 10_000
    localparam int STR    = 3;
    localparam int HB     = 4;

    logic       sysclk    = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [5:0] cpu_led   = 6'h00;
    logic       run_n     = 1'b1;
    logic       uart_rx   = 1'b1;
    logic       uart_tx   = 1'b1;
    logic [5:0] led;

    int checks   = 0;
    int failures = 0;

    always #5 sysclk = ~sysclk;

    board_led_ctrl #(
        .CLK_HZ     (10_000),
        .STRETCH_MS (STR),
        .HB_HALF_MS (HB)
    ) dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .cpu_led   (cpu_led),
        .run_n     (run_n),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .led       (led)
    );

    // ---------------- reference model ----------------
    // Cycle c counts from reset release; a ms tick falls in every cycle with c%10==9.
    // m_last[i]: cycle of the most recent trigger on stretch channel i.
    int   m_last [3];
    bit   m_has  [3];
    int   m_c0;
    bit   m_run;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_last[i] = 0;
            m_has[i]  = 1'b0;
        end
        m_c0  = 0;
        m_run = 1'b0;
    endfunction

    // Given synchronized inputs seen in cycle c, the LED vector shown in cycle c+1.
    function automatic logic [5:0] model_step(input int c, input logic [5:0] cl,
                                              input logic rn, input logic rx, input logic tx);
        logic [5:0] e;
        logic [2:0] trg;
        bit         lit;
        int         rem;
        int         n;
        trg  = {~tx, ~rx, cl[3]};
        e    = 6'h3F;
        e[0] = ~cl[0];
        e[1] = ~cl[1];
        for (int i = 0; i < 3; i++) begin
            lit = trg[i];
            if (!lit && m_has[i]) begin
                // full on-time minus the ticks seen since the trigger cycle
                rem = STR - (c / MS_DIV - (m_last[i] + 1) / MS_DIV);
                lit = (rem > 0);
            end
            if (trg[i]) begin
                m_has[i]  = 1'b1;
                m_last[i] = c;
            end
            e[3 + i] = ~lit;
        end
`ifdef LED_HEARTBEAT_EN
        if (rn) begin
            m_run = 1'b0;
            e[2]  = 1'b1;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_c0  = c;
            end
            n    = (c + 1) / MS_DIV - (m_c0 + 1) / MS_DIV;
            e[2] = ((n / HB) % 2) != 0;
        end
`else
        n    = 0;
        e[2] = rn;
`endif
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [5:0] exp_q [$];
    bit         mon_active = 1'b0;
    int         mon_cyc    = 0;
    logic [5:0] mon_exp;

    always @(posedge sysclk) begin
        if (mon_active) begin
            #2;
            mon_cyc++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow cyc=%0d led=%b", mon_cyc, led);
            end else begin
                mon_exp = exp_q.pop_front();
                if (led !== mon_exp) begin
                    failures++;
                    $display("FAIL led cyc=%0d got=%b exp=%b", mon_cyc, led, mon_exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int   cyc;
    logic cur_rn;

    task automatic direct_check(input string name, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, want);
        end
    endtask

    // Called on a negedge: apply inputs for this cycle and queue their effect 3 cycles out.
    task automatic drive(input logic [5:0] cl, input logic rn, input logic rx, input logic tx);
        cpu_led = cl;
        run_n   = rn;
        uart_rx = rx;
        uart_tx = tx;
        exp_q.push_back(model_step(cyc + 2, cl, rn, rx, tx));
        cyc++;
        @(negedge sysclk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(6'h00, cur_rn, 1'b1, 1'b1);
    endtask

    task automatic release_reset();
        cpu_led   = 6'h00;
        run_n     = 1'b1;
        uart_rx   = 1'b1;
        uart_tx   = 1'b1;
        cur_rn    = 1'b1;
        model_reset();
        exp_q.delete();
        // cycles 0 and 1 still see the synchronizer reset values
        exp_q.push_back(model_step(0, 6'h00, 1'b1, 1'b1, 1'b1));
        exp_q.push_back(model_step(1, 6'h00, 1'b1, 1'b1, 1'b1));
        cyc        = 0;
        mon_cyc    = 0;
        sys_rst_n  = 1'b1;
        mon_active = 1'b1;
        #1;
        direct_check("post_release", led, 6'h3F);
    endtask

    task automatic random_run(input int n);
        logic [5:0] cl;
        for (int i = 0; i < n; i++) begin
            cl    = 6'($urandom());
            cl[3] = ($urandom_range(15, 0) == 0);
            if ($urandom_range(59, 0) == 0) cur_rn = ~cur_rn;
            drive(cl, cur_rn, $urandom_range(23, 0) != 0, $urandom_range(23, 0) != 0);
        end
    endtask

    initial begin
        // reset held with toggling inputs: LEDs stay dark
        for (int i = 0; i < 12; i++) begin
            @(negedge sysclk);
            cpu_led = 6'($urandom());
            run_n   = 1'($urandom());
            uart_rx = 1'($urandom());
            uart_tx = 1'($urandom());
            #1;
            direct_check("in_reset", led, 6'h3F);
        end
        @(negedge sysclk);
        release_reset();

        // steady red/green
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 5; i++) drive(6'(p), cur_rn, 1'b1, 1'b1);
        end
        idle(4);

        // run indicator / heartbeat, then leave run
        cur_rn = 1'b0;
        idle(100);
        cur_rn = 1'b1;
        idle(10);

        // single-cycle RX pulse
        drive(6'h00, cur_rn, 1'b0, 1'b1);
        idle(40);

        // CPU grant retrigger at t=0 and t=25
        drive(6'h08, cur_rn, 1'b1, 1'b1);
        idle(24);
        drive(6'h08, cur_rn, 1'b1, 1'b1);
        idle(40);

        // TX trigger arriving at the synchronizer output on a tick cycle
        while (((cyc + 2) % MS_DIV) != MS_DIV - 1) idle(1);
        drive(6'h00, cur_rn, 1'b1, 1'b0);
        idle(40);

        random_run(1500);

        // reset in the middle of an RX stretch
        cur_rn = 1'b1;
        idle(2);
        drive(6'h00, cur_rn, 1'b0, 1'b1);
        idle(6);
        mon_active = 1'b0;
        #1;
        sys_rst_n = 1'b0;
        #1;
        direct_check("async_reset_led4", {5'b0, led[4]}, 6'h01);
        direct_check("async_reset_all", led, 6'h3F);
        exp_q.delete();
        repeat (3) @(negedge sysclk);
        release_reset();
        idle(50);
        random_run(300);
        idle(5);

        mon_active = 1'b0;
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
